bcd_entry_to_bin: RTL
=====================

BCD_ENTRY_TO_BIN -- requirements
Module: bcd_entry_to_bin

Interface
REQ-001 The block SHALL have no parameters; the output is fixed at 8-bit two's complement with a maximum of 3 decimal digits.
REQ-002 The ports SHALL be:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort of the current entry
- digit_valid  input  1  a BCD digit is offered
- digit  input  4  BCD digit, 0-9
- digit_ready  output  1  the block accepts a digit this cycle
- sign_key  input  1  one-cycle pulse that toggles the negative flag
- enter  input  1  one-cycle pulse that ends the entry and starts conversion
- bin_data  output  8  signed binary result
- out_err  output  1  result out of range or entry invalid
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result

Function
REQ-003 The FSM SHALL have three states: IDLE (no digits held), ACCUM (1-3 digits held), HOLD (result presented).
REQ-004 A digit SHALL be consumed only when digit_valid && digit_ready; digit_ready = (state != HOLD) && !enter && !clear.
REQ-005 On each consumed digit, acc SHALL be updated as acc <= acc*10 + digit; acc is 10 bits wide; IDLE->ACCUM on the first digit.
REQ-006 A consumed digit when 3 digits are already held SHALL leave acc unchanged and set the sticky flag ovf.
REQ-007 A digit value greater than 9 SHALL be consumed but discarded, and SHALL set ovf.
REQ-008 sign_key in IDLE or ACCUM SHALL toggle neg; sign_key SHALL be ignored in HOLD.
REQ-009 enter in IDLE or ACCUM SHALL move to HOLD with out_valid asserted on the next cycle, i.e. 1-cycle latency.
REQ-010 Result rules: if ovf is set, or !neg and acc>127, or neg and acc>128, then bin_data=0 and out_err=1; otherwise bin_data = neg ? -acc : acc (8 bits) and out_err=0.
REQ-011 An entry of -0 SHALL produce bin_data=0 with out_err=0.
REQ-012 enter with no digits held SHALL produce bin_data=0 with out_err=0.
REQ-013 In HOLD, bin_data, out_err and out_valid SHALL remain stable until out_valid && out_ready.
REQ-014 On acceptance the block SHALL go to IDLE with acc, neg, ovf and the digit count cleared, and out_valid low on the next cycle.
REQ-015 enter in HOLD SHALL be ignored.
REQ-016 clear SHALL have priority over all inputs: next state IDLE, all internal state cleared, out_valid=0, including a result pending in HOLD.
REQ-017 When enter and digit_valid occur in the same cycle, enter SHALL win and the digit SHALL not be consumed.
REQ-018 sign_key in the same cycle as enter SHALL be applied before the result is formed.

Reset
REQ-019 While rst_n=0, the block SHALL hold state=IDLE, acc=0, neg=0, ovf=0, count=0, bin_data=0, out_err=0 and out_valid=0 asynchronously.
REQ-020 Reset mid-entry or in HOLD SHALL discard all progress; the first clk edge after release SHALL behave as IDLE.

Configuration
REQ-021 With macro BCD_ENTRY_ECHO_EN defined, the block SHALL add registered outputs echo_ones[3:0], echo_tens[3:0], echo_hundreds[3:0] and echo_sign.
REQ-022 The echo outputs SHALL show the digits entered so far, right-aligned and shifted left on each new digit, for feeding the team's 7-segment digit decoders during typing.
REQ-023 The echo outputs SHALL be cleared by reset, clear and acceptance.
REQ-024 Without BCD_ENTRY_ECHO_EN, these ports and registers SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-025 Package bcd_entry_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD) and the constants MAX_DIGITS=3, POS_LIMIT=127, NEG_LIMIT=128 and ACC_W=10.
REQ-026 Sub-module bcd_mac10 SHALL be combinational and compute acc*10+digit using shift-add ((acc<<3)+(acc<<1)+digit); no multiplier SHALL be inferred.

Verification
REQ-027 Digits 1,2,7 then enter -> bin_data=8'h7F, out_err=0, out_valid one cycle after enter.
REQ-028 sign_key, then digits 1,2,8, then enter -> bin_data=8'h80, out_err=0.
REQ-029 Digits 1,2,8 then enter without sign -> bin_data=0, out_err=1; likewise digits 1,2,3,4 then enter -> out_err=1 via ovf.
REQ-030 Result pending with out_ready=0 for 5 cycles, digit_valid=1 and enter pulses applied -> outputs stable and digit_ready=0; out_ready=1 -> next cycle out_valid=0, state IDLE.
REQ-031 enter and digit_valid (digit=5) in the same cycle after digit 4 -> result 8'h04 and digit 5 not consumed.
REQ-032 rst_n pulled low after digits 9,9 -> all outputs 0 immediately; a later enter with no digits -> bin_data=0, out_err=0.

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// rtl/bcd_entry_pkg.sv - shared types, limits and result helper for BCD keypad entry
//
// Purpose: state enum, entry limits and the range-check/negate helper used by
//          bcd_entry_to_bin.
// Ports:   none (package).

package bcd_entry_pkg;

  localparam int ACC_W = 10;

  localparam logic [1:0]       MAX_DIGITS = 2'd3;
  localparam logic [ACC_W-1:0] POS_LIMIT  = 10'd127;
  localparam logic [ACC_W-1:0] NEG_LIMIT  = 10'd128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] bin;
    logic       err;
  } result_t;

  // Range check and two's complement conversion of a magnitude plus sign.
  // -0 naturally yields 0 because ~0 + 1 wraps to 0 in 8 bits.
  function automatic result_t form_result(input logic [ACC_W-1:0] acc,
                                          input logic             neg,
                                          input logic             ovf);
    result_t r;
    if (ovf || (!neg && (acc > POS_LIMIT)) || (neg && (acc > NEG_LIMIT))) begin
      r.bin = 8'd0;
      r.err = 1'b1;
    end else begin
      r.bin = neg ? (~acc[7:0] + 8'd1) : acc[7:0];
      r.err = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// rtl/bcd_mac10.sv - combinational acc*10+digit using shift-add
//
// Purpose: one decimal accumulate step without a multiplier.
// Ports:   acc    - current accumulator (ACC_W bits)
//          digit  - BCD digit to append
//          result - acc*10 + digit, truncated to ACC_W bits

module bcd_mac10
  import bcd_entry_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] result
);

  // acc*8 + acc*2 + digit; only called with acc <= 99, so 999 fits in 10 bits.
  assign result = {acc[ACC_W-4:0], 3'b000}
                + {acc[ACC_W-2:0], 1'b0}
                + {{(ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/bcd_entry_to_bin.sv
// rtl/bcd_entry_to_bin.sv - keypad BCD digit entry to 8-bit signed binary
//
// Purpose: collects up to three BCD digits and a sign toggle, converts on
//          enter, and holds the result until the consumer accepts it.
// Ports:   clk, rst_n (async active-low)
//          clear                        - synchronous abort, highest priority
//          digit_valid/digit/digit_ready - digit offer handshake
//          sign_key                     - toggles negative flag
//          enter                        - ends entry, result next cycle
//          bin_data/out_err/out_valid/out_ready - result handshake
// Option:  BCD_ENTRY_ECHO_EN adds echo_ones/echo_tens/echo_hundreds/echo_sign
//          showing the digits typed so far.

module bcd_entry_to_bin
  import bcd_entry_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic       digit_ready,
  input  logic       sign_key,
  input  logic       enter,
  output logic [7:0] bin_data,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready
`ifdef BCD_ENTRY_ECHO_EN
  ,
  output logic [3:0] echo_ones,
  output logic [3:0] echo_tens,
  output logic [3:0] echo_hundreds,
  output logic       echo_sign
`endif
);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, mac_out;
  logic             neg, neg_n;
  logic             ovf, ovf_n;
  logic [1:0]       count, count_n;
  logic [7:0]       bin_n;
  logic             err_n;
  logic             valid_n;
  result_t          res;

`ifdef BCD_ENTRY_ECHO_EN
  logic [3:0] echo_ones_n, echo_tens_n, echo_hundreds_n;
  logic       echo_sign_n;
`endif

  bcd_mac10 u_mac10 (
    .acc    (acc),
    .digit  (digit),
    .result (mac_out)
  );

  assign digit_ready = (state != HOLD) && !enter && !clear;

  // The sign toggled in the enter cycle must already count for the result.
  assign res = form_result(acc, neg ^ sign_key, ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      count     <= 2'd0;
      bin_data  <= 8'd0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
`ifdef BCD_ENTRY_ECHO_EN
      echo_ones     <= 4'd0;
      echo_tens     <= 4'd0;
      echo_hundreds <= 4'd0;
      echo_sign     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      neg       <= neg_n;
      ovf       <= ovf_n;
      count     <= count_n;
      bin_data  <= bin_n;
      out_err   <= err_n;
      out_valid <= valid_n;
`ifdef BCD_ENTRY_ECHO_EN
      echo_ones     <= echo_ones_n;
      echo_tens     <= echo_tens_n;
      echo_hundreds <= echo_hundreds_n;
      echo_sign     <= echo_sign_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    neg_n   = neg;
    ovf_n   = ovf;
    count_n = count;
    bin_n   = bin_data;
    err_n   = out_err;
    valid_n = out_valid;
`ifdef BCD_ENTRY_ECHO_EN
    echo_ones_n     = echo_ones;
    echo_tens_n     = echo_tens;
    echo_hundreds_n = echo_hundreds;
    echo_sign_n     = echo_sign;
`endif

    if (clear) begin
      state_n = IDLE;
      acc_n   = '0;
      neg_n   = 1'b0;
      ovf_n   = 1'b0;
      count_n = 2'd0;
      bin_n   = 8'd0;
      err_n   = 1'b0;
      valid_n = 1'b0;
`ifdef BCD_ENTRY_ECHO_EN
      echo_ones_n     = 4'd0;
      echo_tens_n     = 4'd0;
      echo_hundreds_n = 4'd0;
      echo_sign_n     = 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (sign_key) begin
            neg_n = !neg;
          end
          if (enter) begin
            // enter wins over a digit offered in the same cycle
            state_n = HOLD;
            bin_n   = res.bin;
            err_n   = res.err;
            valid_n = 1'b1;
          end else if (digit_valid) begin
            if ((digit > 4'd9) || (count == MAX_DIGITS)) begin
              // consumed but discarded; the entry is now invalid
              ovf_n = 1'b1;
            end else begin
              acc_n   = mac_out;
              count_n = count + 2'd1;
              state_n = ACCUM;
`ifdef BCD_ENTRY_ECHO_EN
              echo_hundreds_n = echo_tens;
              echo_tens_n     = echo_ones;
              echo_ones_n     = digit;
`endif
            end
          end
`ifdef BCD_ENTRY_ECHO_EN
          echo_sign_n = neg_n;
`endif
        end
        HOLD: begin
          if (out_ready) begin
            state_n = IDLE;
            acc_n   = '0;
            neg_n   = 1'b0;
            ovf_n   = 1'b0;
            count_n = 2'd0;
            bin_n   = 8'd0;
            err_n   = 1'b0;
            valid_n = 1'b0;
`ifdef BCD_ENTRY_ECHO_EN
            echo_ones_n     = 4'd0;
            echo_tens_n     = 4'd0;
            echo_hundreds_n = 4'd0;
            echo_sign_n     = 1'b0;
`endif
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule
